// File: rtl/read_sm_pkg.sv
// Shared types and width helpers for the burst read sequencer.
package read_sm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } rd_state_t;

  // $clog2 with a floor of 1 so that degenerate sizes still yield a usable vector
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hs_stall_timer.sv
// Counts edges spent waiting on a handshake level; flags the edge that would
// bring the count up to TIMEOUT_CYCLES.
module hs_stall_timer
  import read_sm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TO_W = clog2_min1(TIMEOUT_CYCLES + 1);
  // The count sits at TIMEOUT_CYCLES-1 when one more stalled edge reaches the limit
  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Next count: clear wins over increment so a state change always restarts the window
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Stall count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST_CNT);

endmodule

// File: rtl/burst_read_sm.sv
// Multi-word read sequencer: one run pulse fetches NUM_WORDS words over a
// two-phase (high = ready, low = released) handshake, with stall abort.
module burst_read_sm
  import read_sm_pkg::*;
#(
  parameter  int NUM_WORDS      = 4,
  parameter  int DATA_W         = 16,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int IDX_W          = clog2_min1(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              handshake,
  input  logic [DATA_W-1:0] rd_data,
  output logic              read,
  output logic [DATA_W-1:0] word_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  rd_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              read_q, read_d;
  logic [DATA_W-1:0] word_out_q, word_out_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              stall;
  logic              state_change;
  logic              expired;

  assign state_change = (state_d != state_q);

  // Stall timer exists only when a limit is configured
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      hs_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state_change),
        .enable (stall),
        .expired(expired)
      );
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

  // Next-state and next-output logic; pulses default low, captured data holds
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    read_d     = 1'b0;
    word_out_d = word_out_q;
    word_idx_d = word_idx_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = WAIT_HI;
          idx_d   = '0;
        end
      end
      WAIT_HI: begin
        if (handshake) begin
          read_d     = 1'b1;
          word_out_d = rd_data;
          word_idx_d = idx_q;
          state_d    = WAIT_LO;
        end else begin
          stall = 1'b1;
          if (expired) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            idx_d     = '0;
          end
        end
      end
      WAIT_LO: begin
        if (!handshake) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = WAIT_HI;
          end
        end else begin
          stall = 1'b1;
          if (expired) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            idx_d     = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, index and output registers; reset clears everything even mid-burst
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      read_q     <= 1'b0;
      word_out_q <= '0;
      word_idx_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      read_q     <= read_d;
      word_out_q <= word_out_d;
      word_idx_q <= word_idx_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign read       = read_q;
  assign word_valid = read_q;
  assign word_out   = word_out_q;
  assign word_idx   = word_idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_burst_read_sm.sv
// Directed bench for burst_read_sm: a 4-word/8-cycle-timeout build and a
// 1-word/no-timeout build share the clock and reset.
module tb_burst_read_sm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Main build
  logic        run0 = 1'b0, hs0 = 1'b0;
  logic [15:0] data0 = '0;
  logic        rd0, wv0, busy0, done0, to0;
  logic [15:0] wo0;
  logic [1:0]  idx0;

  burst_read_sm #(.NUM_WORDS(4), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .run(run0), .handshake(hs0), .rd_data(data0),
    .read(rd0), .word_out(wo0), .word_idx(idx0), .word_valid(wv0),
    .busy(busy0), .done(done0), .timeout(to0)
  );

  // Single-word build without timeout
  logic        run1 = 1'b0, hs1 = 1'b0;
  logic [15:0] data1 = '0;
  logic        rd1, wv1, busy1, done1, to1;
  logic [15:0] wo1;
  logic [0:0]  idx1;

  burst_read_sm #(.NUM_WORDS(1), .DATA_W(16), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .run(run1), .handshake(hs1), .rd_data(data1),
    .read(rd1), .word_out(wo1), .word_idx(idx1), .word_valid(wv1),
    .busy(busy1), .done(done1), .timeout(to1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on dut0: drive, clock, compare every output
  task automatic step0(input logic r, input logic h, input logic [15:0] d,
                       input logic e_rd, input logic [15:0] e_wo, input logic [1:0] e_idx,
                       input logic e_busy, input logic e_done, input logic e_to,
                       input string tag);
    run0 = r; hs0 = h; data0 = d;
    tick();
    chk({tag, ".read"}, 32'(rd0), 32'(e_rd));
    chk({tag, ".word_valid"}, 32'(wv0), 32'(e_rd));
    chk({tag, ".word_out"}, 32'(wo0), 32'(e_wo));
    chk({tag, ".word_idx"}, 32'(idx0), 32'(e_idx));
    chk({tag, ".busy"}, 32'(busy0), 32'(e_busy));
    chk({tag, ".done"}, 32'(done0), 32'(e_done));
    chk({tag, ".timeout"}, 32'(to0), 32'(e_to));
    $display("dut0 %s run=%0b hs=%0b d=%h -> rd=%0b wo=%h idx=%0d busy=%0b done=%0b to=%0b",
             tag, r, h, d, rd0, wo0, idx0, busy0, done0, to0);
  endtask

  task automatic step1(input logic r, input logic h, input logic [15:0] d,
                       input logic e_rd, input logic [15:0] e_wo,
                       input logic e_busy, input logic e_done, input string tag);
    run1 = r; hs1 = h; data1 = d;
    tick();
    chk({tag, ".read"}, 32'(rd1), 32'(e_rd));
    chk({tag, ".word_out"}, 32'(wo1), 32'(e_wo));
    chk({tag, ".word_idx"}, 32'(idx1), 32'd0);
    chk({tag, ".busy"}, 32'(busy1), 32'(e_busy));
    chk({tag, ".done"}, 32'(done1), 32'(e_done));
    chk({tag, ".timeout"}, 32'(to1), 32'd0);
    $display("dut1 %s run=%0b hs=%0b d=%h -> rd=%0b wo=%h busy=%0b done=%0b to=%0b",
             tag, r, h, d, rd1, wo1, busy1, done1, to1);
  endtask

  // Pulse and exclusivity properties checked every cycle on both builds
  logic prev_rd0 = 1'b0, prev_done0 = 1'b0, prev_to0 = 1'b0;
  logic prev_rd1 = 1'b0, prev_done1 = 1'b0;
  always @(negedge clk) begin
    chk("prop0.read_eq_valid", 32'(wv0), 32'(rd0));
    chk("prop0.done_and_timeout", 32'(done0 & to0), 32'd0);
    if (prev_rd0) chk("prop0.read_pulse", 32'(rd0), 32'd0);
    if (prev_done0) chk("prop0.done_pulse", 32'(done0), 32'd0);
    if (prev_to0) chk("prop0.timeout_pulse", 32'(to0), 32'd0);
    chk("prop1.read_eq_valid", 32'(wv1), 32'(rd1));
    if (prev_rd1) chk("prop1.read_pulse", 32'(rd1), 32'd0);
    if (prev_done1) chk("prop1.done_pulse", 32'(done1), 32'd0);
    prev_rd0 = rd0; prev_done0 = done0; prev_to0 = to0;
    prev_rd1 = rd1; prev_done1 = done1;
  end

  typedef struct packed {
    logic        run;
    logic        hs;
    logic [15:0] data;
    logic        e_rd;
    logic [15:0] e_wo;
    logic [1:0]  e_idx;
    logic        e_busy;
    logic        e_done;
    logic        e_to;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // run, hs, data, read, word_out, word_idx, busy, done, timeout
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h1111, 1'b1, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'hEEEE, 1'b0, 16'h1111, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h2222, 1'b1, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h2222, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h3333, 1'b1, 16'h3333, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h3333, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h4444, 1'b1, 16'h4444, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h4444, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h4444, 2'd3, 1'b0, 1'b0, 1'b0};
    // second burst: run pulsed mid-burst is ignored, run in the done cycle restarts
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h4444, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'hAAAA, 1'b1, 16'hAAAA, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'hEEEE, 1'b0, 16'hAAAA, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'hBBBB, 1'b1, 16'hBBBB, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hBBBB, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 16'hCCCC, 1'b1, 16'hCCCC, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hCCCC, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 16'hDDDD, 1'b1, 16'hDDDD, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 2'd3, 1'b1, 1'b0, 1'b0};

    // Reset state
    #1;
    chk("reset.busy0", 32'(busy0), 32'd0);
    chk("reset.word_out0", 32'(wo0), 32'd0);
    chk("reset.read0", 32'(rd0), 32'd0);
    chk("reset.busy1", 32'(busy1), 32'd0);
    tick();
    reset_n = 1'b1;

    // Nominal bursts from the table; the last vector leaves a burst just started
    for (int i = 0; i < 20; i++) begin
      step0(vecs[i].run, vecs[i].hs, vecs[i].data, vecs[i].e_rd, vecs[i].e_wo,
            vecs[i].e_idx, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_to,
            $sformatf("vec%0d", i));
    end

    // Stall in WAIT_HI: timeout on the 8th stalled edge, outputs hold
    for (int i = 1; i <= 8; i++) begin
      step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 2'd3, (i < 8), 1'b0, (i == 8),
            $sformatf("stall_hi%0d", i));
    end
    step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 2'd3, 1'b0, 1'b0, 1'b0, "after_to_hi");

    // Stall in WAIT_LO on word 1
    step0(1'b1, 1'b0, 16'h0000, 1'b0, 16'hDDDD, 2'd3, 1'b1, 1'b0, 1'b0, "lo_run");
    step0(1'b0, 1'b1, 16'h0101, 1'b1, 16'h0101, 2'd0, 1'b1, 1'b0, 1'b0, "lo_w0");
    step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0101, 2'd0, 1'b1, 1'b0, 1'b0, "lo_w0rel");
    step0(1'b0, 1'b1, 16'h0202, 1'b1, 16'h0202, 2'd1, 1'b1, 1'b0, 1'b0, "lo_w1");
    for (int i = 1; i <= 8; i++) begin
      step0(1'b0, 1'b1, 16'h0F0F, 1'b0, 16'h0202, 2'd1, (i < 8), 1'b0, (i == 8),
            $sformatf("stall_lo%0d", i));
    end
    step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0202, 2'd1, 1'b0, 1'b0, 1'b0, "after_to_lo");

    // Handshake rises on the edge that would hit the limit: read wins
    step0(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0202, 2'd1, 1'b1, 1'b0, 1'b0, "conf_run");
    for (int i = 1; i <= 7; i++) begin
      step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0202, 2'd1, 1'b1, 1'b0, 1'b0,
            $sformatf("conf_wait%0d", i));
    end
    step0(1'b0, 1'b1, 16'h0303, 1'b1, 16'h0303, 2'd0, 1'b1, 1'b0, 1'b0, "conf_edge8");
    step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0303, 2'd0, 1'b1, 1'b0, 1'b0, "conf_rel0");
    step0(1'b0, 1'b1, 16'h0404, 1'b1, 16'h0404, 2'd1, 1'b1, 1'b0, 1'b0, "conf_w1");
    step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0404, 2'd1, 1'b1, 1'b0, 1'b0, "conf_rel1");
    step0(1'b0, 1'b1, 16'h0505, 1'b1, 16'h0505, 2'd2, 1'b1, 1'b0, 1'b0, "conf_w2");

    // Reset while in WAIT_LO with idx=2: outputs clear without waiting for an edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid.read", 32'(rd0), 32'd0);
    chk("rst_mid.word_valid", 32'(wv0), 32'd0);
    chk("rst_mid.word_out", 32'(wo0), 32'd0);
    chk("rst_mid.word_idx", 32'(idx0), 32'd0);
    chk("rst_mid.busy", 32'(busy0), 32'd0);
    chk("rst_mid.done", 32'(done0), 32'd0);
    chk("rst_mid.timeout", 32'(to0), 32'd0);
    $display("dut0 rst_mid -> rd=%0b wo=%h idx=%0d busy=%0b done=%0b", rd0, wo0, idx0, busy0, done0);
    hs0 = 1'b0;
    tick();
    reset_n = 1'b1;
    step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, "rst_after1");
    step0(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, "rst_after2");

    // Single-word build, no timeout
    step1(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, "n1_run");
    step1(1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0, "n1_word");
    step1(1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b1, "n1_done");
    step1(1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, "n1_idle");
    step1(1'b1, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, "n1_run2");
    for (int i = 1; i <= 100; i++) begin
      step1(1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, $sformatf("n1_stall%0d", i));
    end
    step1(1'b0, 1'b1, 16'h5678, 1'b1, 16'h5678, 1'b1, 1'b0, "n1_word2");
    step1(1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 1'b1, "n1_done2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
